// File: rtl/portal_pkg.sv
// Shared definitions for the portal layer: header field layout, word size
// and error-counter width used by the pipe-to-method demultiplexer.
package portal_pkg;

  localparam int ID_MSB          = 15;
  localparam int ID_LSB          = 8;
  localparam int LEN_MSB         = 7;
  localparam int LEN_LSB         = 0;
  localparam int WORD_WIDTH      = 32;
  localparam int ERR_COUNT_WIDTH = 16;

  localparam logic [ERR_COUNT_WIDTH-1:0] ERR_COUNT_MAX = '1;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] len;
  } hdr_t;

endpackage

// File: rtl/portal_fifo2.sv
// Two-entry FIFO with ENA/RDY handshakes on both sides; enqueue readiness
// depends only on occupancy, never on a same-cycle dequeue.
module portal_fifo2 #(
  parameter int WIDTH = 144
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enq_ena,
  input  logic [WIDTH-1:0] i_enq_data,
  output logic             o_enq_rdy,
  input  logic             i_deq_ena,
  output logic             o_deq_rdy,
  output logic [WIDTH-1:0] o_deq_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             w_enq;
  logic             w_deq;

  assign o_enq_rdy  = (r_count < 2'd2);
  assign o_deq_rdy  = (r_count != 2'd0);
  assign o_deq_data = r_mem[r_rd_ptr];
  assign w_enq      = i_enq_ena && o_enq_rdy;
  assign w_deq      = i_deq_ena && o_deq_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= i_enq_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

endmodule

// File: rtl/portal_p2m_demux.sv
// Pipe-to-method demultiplexer: queues {header, payload} messages, masks the
// payload to its length, dispatches by method id and drops malformed messages.
module portal_p2m_demux
  import portal_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int HDR_WIDTH   = 16,
  parameter int NUM_METHODS = 4
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            pipeEnqEna,
  input  logic [HDR_WIDTH+DATA_WIDTH-1:0] pipeEnqV,
  output logic                            pipeEnqRdy,
  output logic [NUM_METHODS-1:0]          methodEnqEna,
  output logic [DATA_WIDTH-1:0]           methodEnqV,
  input  logic [NUM_METHODS-1:0]          methodEnqRdy,
  input  logic                            errClearEna,
  output logic [ERR_COUNT_WIDTH-1:0]      errCount,
  output logic [ERR_COUNT_WIDTH-1:0]      errLastHdr
);

  localparam int ENTRY_WIDTH = HDR_WIDTH + DATA_WIDTH;
  localparam int NUM_WORDS   = DATA_WIDTH / WORD_WIDTH;

  logic [ENTRY_WIDTH-1:0]     w_head;
  logic                       w_head_valid;
  logic                       w_pop;
  logic                       w_drop;
  logic                       w_bad;
  hdr_t                       w_hdr;
  logic [7:0]                 w_id;
  logic [7:0]                 w_len;
  logic [DATA_WIDTH-1:0]      w_masked;
  logic [NUM_METHODS-1:0]     w_ena;
  logic [ERR_COUNT_WIDTH-1:0] r_err_count;
  logic [ERR_COUNT_WIDTH-1:0] r_last_hdr;

  portal_fifo2 #(
    .WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .i_enq_ena (pipeEnqEna),
    .i_enq_data(pipeEnqV),
    .o_enq_rdy (pipeEnqRdy),
    .i_deq_ena (w_pop),
    .o_deq_rdy (w_head_valid),
    .o_deq_data(w_head)
  );

  assign w_hdr = w_head[ENTRY_WIDTH-1 -: HDR_WIDTH];
  assign w_id  = w_hdr[ID_MSB:ID_LSB];
  assign w_len = w_hdr[LEN_MSB:LEN_LSB];
  assign w_bad = (int'(w_id) >= NUM_METHODS) || (int'(w_len) > NUM_WORDS);

  always_comb begin
    w_masked = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (k < int'(w_len))
        w_masked[k*WORD_WIDTH +: WORD_WIDTH] = w_head[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Only the addressed channel can fire; a stalled head blocks everything behind it.
  always_comb begin
    w_ena = '0;
    for (int m = 0; m < NUM_METHODS; m++) begin
      w_ena[m] = w_head_valid && !w_bad && methodEnqRdy[m] && (int'(w_id) == m);
    end
  end

  assign w_drop       = w_head_valid && w_bad;
  assign w_pop        = (|w_ena) || w_drop;
  assign methodEnqEna = w_ena;
  assign methodEnqV   = w_head_valid ? w_masked : '0;

  // A clear coinciding with a drop leaves that drop counted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_err_count <= '0;
      r_last_hdr  <= '0;
    end else begin
      if (w_drop) r_last_hdr <= w_hdr;
      if (errClearEna)
        r_err_count <= w_drop ? ERR_COUNT_WIDTH'(1) : '0;
      else if (w_drop && (r_err_count != ERR_COUNT_MAX))
        r_err_count <= r_err_count + 1'b1;
    end
  end

  assign errCount   = r_err_count;
  assign errLastHdr = r_last_hdr;

endmodule

// File: tb/tb_portal_p2m_demux.sv
// Directed self-checking bench for portal_p2m_demux with hand-computed expectations.
module tb_portal_p2m_demux;

  logic         CLK;
  logic         nRST;
  logic         pipeEna;
  logic [143:0] pipeV;
  logic         pipeRdy;
  logic [3:0]   methodEna;
  logic [127:0] methodV;
  logic [3:0]   methodRdy;
  logic         errClear;
  logic [15:0]  errCount;
  logic [15:0]  errLastHdr;

  int checkCount;
  int passCount;

  portal_p2m_demux #(
    .DATA_WIDTH (128),
    .HDR_WIDTH  (16),
    .NUM_METHODS(4)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .pipeEnqEna  (pipeEna),
    .pipeEnqV    (pipeV),
    .pipeEnqRdy  (pipeRdy),
    .methodEnqEna(methodEna),
    .methodEnqV  (methodV),
    .methodEnqRdy(methodRdy),
    .errClearEna (errClear),
    .errCount    (errCount),
    .errLastHdr  (errLastHdr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] hdr, input logic [127:0] payload);
    pipeV   = {hdr, payload};
    pipeEna = 1'b1;
  endtask

  task automatic idle();
    pipeEna = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    nRST       = 1'b0;
    pipeEna    = 1'b0;
    pipeV      = '0;
    methodRdy  = 4'hF;
    errClear   = 1'b0;
    #12;
    checkOutput("rst_pipe_rdy", pipeRdy, 1);
    checkOutput("rst_ena", methodEna, 0);
    checkOutput("rst_v", methodV, 0);
    checkOutput("rst_err_count", errCount, 0);
    checkOutput("rst_last_hdr", errLastHdr, 0);
    nRST = 1'b1;
    tick();

    // Basic dispatch to method 2 with four payload words
    send(16'h0204, {32'd4, 32'd3, 32'd2, 32'd1});
    #1;
    checkOutput("t1_no_comb_path", methodEna, 0);
    tick();
    idle();
    #1;
    checkOutput("t1_ena", methodEna, 4'b0100);
    checkOutput("t1_v", methodV, {32'd4, 32'd3, 32'd2, 32'd1});
    checkOutput("t1_err_count", errCount, 0);
    tick();
    checkOutput("t1_ena_clear", methodEna, 0);

    // Length masking: only two words survive
    send(16'h0102, {4{32'hFFFF_FFFF}});
    tick();
    idle();
    #1;
    checkOutput("t2_ena", methodEna, 4'b0010);
    checkOutput("t2_v", methodV, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    tick();

    // Malformed messages: bad id then bad length
    send(16'h0701, 128'h1234);
    tick();
    send(16'h0005, {4{32'hDEAD_BEEF}});
    #1;
    checkOutput("t3_bad_id_no_ena", methodEna, 0);
    tick();
    idle();
    #1;
    checkOutput("t3_bad_len_no_ena", methodEna, 0);
    checkOutput("t3_count1", errCount, 1);
    checkOutput("t3_last1", errLastHdr, 16'h0701);
    tick();
    checkOutput("t3_count2", errCount, 2);
    checkOutput("t3_last2", errLastHdr, 16'h0005);
    checkOutput("t3_ena_idle", methodEna, 0);

    // Head-of-line blocking on channel 3
    methodRdy = 4'b0111;
    send(16'h0301, {96'h0, 32'hA1});
    tick();
    send(16'h0301, {96'h0, 32'hA2});
    tick();
    idle();
    #1;
    checkOutput("t4_full_rdy", pipeRdy, 0);
    checkOutput("t4_stalled", methodEna, 0);
    methodRdy = 4'hF;
    #1;
    checkOutput("t4_first_ena", methodEna, 4'b1000);
    checkOutput("t4_first_v", methodV, {96'h0, 32'hA1});
    tick();
    checkOutput("t4_rdy_back", pipeRdy, 1);
    checkOutput("t4_second_ena", methodEna, 4'b1000);
    checkOutput("t4_second_v", methodV, {96'h0, 32'hA2});
    send(16'h0301, {96'h0, 32'hA3});
    tick();
    idle();
    #1;
    checkOutput("t4_third_ena", methodEna, 4'b1000);
    checkOutput("t4_third_v", methodV, {96'h0, 32'hA3});
    tick();
    checkOutput("t4_drained", methodEna, 0);

    // Clear coinciding with a drop leaves the count at one
    send(16'h0900, 128'h0);
    tick();
    idle();
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    #1;
    checkOutput("t5_clear_drop", errCount, 1);
    checkOutput("t5_clear_last", errLastHdr, 16'h0900);

    // Stream drops until the counter reaches its ceiling
    for (int i = 0; i < 65534; i++) begin
      send(16'h0A55, 128'h0);
      tick();
    end
    idle();
    tick();
    checkOutput("t5_at_max", errCount, 16'hFFFF);
    checkOutput("t5_max_last", errLastHdr, 16'h0A55);
    send(16'hFF01, 128'h0);
    tick();
    idle();
    tick();
    checkOutput("t5_saturated", errCount, 16'hFFFF);
    checkOutput("t5_sat_last", errLastHdr, 16'hFF01);

    // Asynchronous reset with two messages queued
    methodRdy = 4'b0111;
    send(16'h0302, {96'h0, 32'h5555_0001});
    tick();
    send(16'h0302, {96'h0, 32'h5555_0002});
    tick();
    idle();
    #1;
    checkOutput("t6_full", pipeRdy, 0);
    #2;
    nRST      = 1'b0;
    methodRdy = 4'hF;
    #1;
    checkOutput("t6_rst_pipe_rdy", pipeRdy, 1);
    checkOutput("t6_rst_ena", methodEna, 0);
    checkOutput("t6_rst_v", methodV, 0);
    checkOutput("t6_rst_count", errCount, 0);
    checkOutput("t6_rst_last", errLastHdr, 0);
    nRST = 1'b1;
    tick();
    checkOutput("t6_post_ena1", methodEna, 0);
    checkOutput("t6_post_rdy", pipeRdy, 1);
    tick();
    checkOutput("t6_post_ena2", methodEna, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
